// File: rtl/vending_state_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : vending_machine_def                                |
// | Description : Shared state encodings and default widths for the  |
// |               vending-machine state controller.                  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package vending_machine_def;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  localparam int kTotalBits      = 31;
  localparam int kNumItems       = 4;
  localparam int kNumCoins       = 3;
  localparam int kTimeoutCycles  = 100;

  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vending_state_ctrl_inactivity_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : inactivity_timer                                   |
// | Description : Saturating idle counter with terminal-count flag.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module inactivity_timer
  import vending_machine_def::*;
#(
  parameter int TIMEOUT_CYCLES = kTimeoutCycles,
  parameter int CW             = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic          clr,
  output logic          terminal,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // clr dominates run; the count parks at C_LAST rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != C_LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign terminal = (r_cnt == C_LAST);
  assign count    = r_cnt;

endmodule
`default_nettype wire

// File: rtl/vending_state_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : vending_state_ctrl                                 |
// | Description : Money/item/change state registers plus IDLE/ACTIVE/|
// |               RETURN FSM with inactivity timeout.                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module vending_state_ctrl
  import vending_machine_def::*;
#(
  parameter int MONEY_W        = kTotalBits,
  parameter int NUM_ITEMS      = kNumItems,
  parameter int NUM_COINS      = kNumCoins,
  parameter int TIMEOUT_CYCLES = kTimeoutCycles
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  upd_en,
  input  logic [MONEY_W-1:0]                    next_money,
  input  logic [NUM_ITEMS-1:0]                  next_item,
  input  logic [NUM_COINS-1:0]                  next_change,
  input  logic                                  activity,
  input  logic                                  clear_req,
  output logic [MONEY_W-1:0]                    current_money,
  output logic [NUM_ITEMS-1:0]                  current_item,
  output logic [NUM_COINS-1:0]                  current_change,
  output logic [1:0]                            state,
  output logic                                  return_busy,
  output logic                                  timeout,
  output logic [cnt_width(TIMEOUT_CYCLES)-1:0]  wait_cnt
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [MONEY_W-1:0]   r_money;
  logic [NUM_ITEMS-1:0] r_item;
  logic [NUM_COINS-1:0] r_change;
  logic [1:0]           r_state;
  logic                 r_timeout;

  logic [1:0]           w_state_nxt;
  logic                 w_timeout_nxt;
  logic                 w_tmr_run;
  logic                 w_tmr_clr;
  logic                 w_terminal;
  logic                 w_upd_zero;
  logic [CW-1:0]        w_wait_cnt;

  assign w_upd_zero = upd_en && (next_money == '0);

  inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CW             (CW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (w_tmr_run),
    .clr      (w_tmr_clr),
    .terminal (w_terminal),
    .count    (w_wait_cnt)
  );

  // The counter only runs in ACTIVE; every ACTIVE exit or activity clears it
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_nxt = 1'b0;
    w_tmr_run     = 1'b0;
    w_tmr_clr     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (upd_en && (next_money != '0)) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_tmr_run = 1'b1;
        w_tmr_clr = 1'b0;
        if (clear_req) begin
          w_state_nxt = ST_RETURN;
          w_tmr_clr   = 1'b1;
        end else if (w_upd_zero) begin
          w_state_nxt = ST_IDLE;
          w_tmr_clr   = 1'b1;
        end else if (activity) begin
          w_tmr_clr   = 1'b1;
        end else if (w_terminal) begin
          w_state_nxt   = ST_RETURN;
          w_timeout_nxt = 1'b1;
          w_tmr_clr     = 1'b1;
        end
      end
      ST_RETURN: begin
        if (w_upd_zero || (!upd_en && (r_money == '0))) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // No dispensing while paying back the balance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_money  <= '0;
      r_item   <= '0;
      r_change <= '0;
    end else if (upd_en) begin
      r_money  <= next_money;
      r_change <= next_change;
      r_item   <= (r_state == ST_RETURN) ? '0 : next_item;
    end
  end

  assign current_money  = r_money;
  assign current_item   = r_item;
  assign current_change = r_change;
  assign state          = r_state;
  assign return_busy    = (r_state == ST_RETURN);
  assign timeout        = r_timeout;
  assign wait_cnt       = w_wait_cnt;

endmodule
`default_nettype wire
